// File: rtl/afifo_pkg.sv
// Shared definitions for the async FIFO write-side blocks.
//   AFIFO_DW_DEFAULT : default FIFO word width
//   clog2_min1()     : ceil(log2(n)), never less than 1, for counter widths
package afifo_pkg;

  localparam int unsigned AFIFO_DW_DEFAULT = 64;

  // A one-lane configuration still needs a 1-bit counter to keep vectors legal.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/afifo_wr_packer.sv
// Write-side width packer in front of afifo_wr_logic (wclk domain).
// Collects RATIO narrow beats LSB-first into one DW-bit word, zero-padding the
// upper lanes when a beat carries last or a flush closes a partial word. One
// completed word is held until the FIFO can take it; push/data are registered.
//
// Ports:
//   wclk, rst_n        write clock, synchronous active-low reset
//   in_valid_i/ready_o beat handshake; in_data_i payload, in_last_i closes word
//   flush_i            close a partial word without a new beat (hold until taken)
//   full_i, al_full_i  back-pressure from afifo_wr_logic
//   push_o, data_in_o  registered write into afifo_wr_logic
//   busy_o             partial, held or pushing data present
module afifo_wr_packer
  import afifo_pkg::*;
#(
  parameter int unsigned DW = AFIFO_DW_DEFAULT,
  parameter int unsigned IW = 16
) (
  input  logic          wclk,
  input  logic          rst_n,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [IW-1:0] in_data_i,
  input  logic          in_last_i,
  input  logic          flush_i,
  input  logic          full_i,
  input  logic          al_full_i,
  output logic          push_o,
  output logic [DW-1:0] data_in_o,
  output logic          busy_o
);

  localparam int unsigned RATIO = DW / IW;
  localparam int unsigned CW    = clog2_min1(RATIO);

  typedef logic [CW-1:0] lane_t;

  if ((DW % IW) != 0) begin : g_bad_cfg
    $error("afifo_wr_packer: DW (%0d) must be a multiple of IW (%0d)", DW, IW);
  end

  logic [DW-1:0] acc_q, acc_d;
  lane_t         cnt_q, cnt_d;
  logic          hold_vld_q, hold_vld_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic          push_q, push_d;
  logic [DW-1:0] data_q, data_d;

  logic          issue;
  logic          beat_acc;
  logic          beat_done;
  logic          flush_done;
  logic          word_done;
  logic [DW-1:0] acc_ins;
  logic [DW-1:0] word;

  // alFull is checked as well as full: it lags inside the FIFO, so stopping on
  // it leaves room for the one push that may already be in flight.
  assign issue      = hold_vld_q & ~full_i & ~al_full_i;
  assign in_ready_o = ~hold_vld_q | issue;
  assign beat_acc   = in_valid_i & in_ready_o;

  // A flush arriving with a beat simply acts as last on that beat.
  assign beat_done  = beat_acc & ((cnt_q == lane_t'(RATIO - 1)) | in_last_i | flush_i);
  assign flush_done = flush_i & ~in_valid_i & in_ready_o & (cnt_q != '0);
  assign word_done  = beat_done | flush_done;

  // acc_ins: accumulator with the current beat dropped into lane cnt.
  // word: the completed word, keeping only lanes already filled plus this beat.
  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    logic hit;
    assign hit = beat_acc & (cnt_q == lane_t'(i));
    assign acc_ins[i*IW +: IW] = hit ? in_data_i : acc_q[i*IW +: IW];
    assign word[i*IW +: IW]    = (hit | (lane_t'(i) < cnt_q)) ? acc_ins[i*IW +: IW] : '0;
  end

  always_comb begin
    acc_d       = acc_ins;
    cnt_d       = cnt_q;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    push_d      = issue;
    data_d      = data_q;

    if (beat_acc) begin
      cnt_d = cnt_q + lane_t'(1);
    end

    if (issue) begin
      data_d     = hold_data_q;
      hold_vld_d = 1'b0;
    end

    // A completion can only be accepted when the hold slot is free or issuing,
    // so overwriting hold_data here never loses a word.
    if (word_done) begin
      acc_d       = '0;
      cnt_d       = '0;
      hold_vld_d  = 1'b1;
      hold_data_d = word;
    end
  end

  always_ff @(posedge wclk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      push_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      push_q      <= push_d;
      data_q      <= data_d;
    end
  end

  assign push_o    = push_q;
  assign data_in_o = data_q;
  assign busy_o    = hold_vld_q | (cnt_q != '0) | push_q;

endmodule

// File: tb/tb_afifo_wr_packer.sv
// Self-checking bench for afifo_wr_packer (DW=64, IW=16).
module tb_afifo_wr_packer;

  localparam int DW = 64;
  localparam int IW = 16;

  logic          wclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [IW-1:0] in_data_i = '0;
  logic          in_last_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          full_i;
  logic          al_full_i = 1'b0;
  logic          push_o;
  logic [DW-1:0] data_in_o;
  logic          busy_o;

  afifo_wr_packer #(
    .DW(DW),
    .IW(IW)
  ) u_dut (
    .wclk      (wclk),
    .rst_n     (rst_n),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .in_data_i (in_data_i),
    .in_last_i (in_last_i),
    .flush_i   (flush_i),
    .full_i    (full_i),
    .al_full_i (al_full_i),
    .push_o    (push_o),
    .data_in_o (data_in_o),
    .busy_o    (busy_o)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_acc = '0;
  int            m_cnt = 0;
  logic          sb_on = 1'b0;
  logic          stream_on = 1'b0;
  logic          blk_prev = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference packing model, advanced only on handshakes the bench completed.
  task automatic model_beat(input logic [IW-1:0] d, input logic last);
    m_acc[m_cnt*IW +: IW] = d;
    if (m_cnt == (DW / IW) - 1 || last) begin
      exp_q.push_back(m_acc);
      m_acc = '0;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic model_flush();
    if (m_cnt != 0) begin
      exp_q.push_back(m_acc);
      m_acc = '0;
      m_cnt = 0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send_beat(input logic [IW-1:0] d, input logic last);
    logic got;
    got        = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = last;
    for (int n = 0; n < 200; n++) begin
      @(negedge wclk);
      if (in_ready_o) begin
        got = 1'b1;
        @(posedge wclk);
        #1;
        break;
      end
      @(posedge wclk);
      #1;
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    if (got) model_beat(d, last);
    else chk("beat_handshake_timeout", 64'(got), 64'(1));
  endtask

  task automatic send_flush();
    logic got;
    got     = 1'b0;
    flush_i = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge wclk);
      if (in_ready_o) begin
        got = 1'b1;
        @(posedge wclk);
        #1;
        break;
      end
      @(posedge wclk);
      #1;
    end
    flush_i = 1'b0;
    if (got) model_flush();
    else chk("flush_handshake_timeout", 64'(got), 64'(1));
  endtask

  task automatic drain();
    repeat (8) begin
      @(posedge wclk);
      #1;
    end
    chk("sb_drain_left", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge wclk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    m_acc = '0;
    m_cnt = 0;
    @(negedge wclk);
    chk("rst_push", 64'(push_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_ready", 64'(in_ready_o), 64'(1));
    @(posedge wclk);
    #1;
  endtask

  // Full toggler: the only writer of full_i.
  always begin
    @(posedge wclk);
    #1;
    full_i = stream_on ? ($urandom_range(0, 2) == 0) : 1'b0;
  end
  initial full_i = 1'b0;

  // Never push when the cycle that issued it saw full/alFull.
  always @(negedge wclk) begin
    if (push_o) chk("push_while_blocked", 64'(blk_prev), 64'(0));
    blk_prev = full_i | al_full_i;
  end

  // Scoreboard: every pushed word must be the next expected one.
  always @(negedge wclk) begin
    if (sb_on && push_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_push actual=%h required=none", data_in_o);
      end else begin
        chk("sb_word", data_in_o, exp_q.pop_front());
      end
    end
  end

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] dat;
    logic          lst;
    logic          fl;
    logic          ready;
    logic          push;
    logic [DW-1:0] data;
    logic          busy;
  } vec_t;

  localparam logic [DW-1:0] W1 = 64'h4444_3333_2222_1111;
  localparam logic [DW-1:0] W2 = 64'h0000_0000_BBBB_AAAA;
  localparam logic [DW-1:0] W3 = 64'h0000_0003_0002_0001;

  vec_t vecs[20];

  initial begin
    vecs[0]  = '{1'b1, 16'h1111, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0};
    vecs[1]  = '{1'b1, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1};
    vecs[2]  = '{1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1};
    vecs[3]  = '{1'b1, 16'h4444, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1};
    vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1};
    vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, W1,    1'b1};
    vecs[6]  = '{1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b1, 1'b0, W1,    1'b0};
    vecs[7]  = '{1'b1, 16'hBBBB, 1'b1, 1'b0, 1'b1, 1'b0, W1,    1'b1};
    vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, W1,    1'b1};
    vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, W2,    1'b1};
    vecs[10] = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, W2,    1'b0};
    vecs[11] = '{1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0, W2,    1'b1};
    vecs[12] = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0, W2,    1'b1};
    vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, W2,    1'b1};
    vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, W2,    1'b1};
    vecs[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, W2,    1'b1};
    vecs[16] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, W3,    1'b1};
    vecs[17] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, W3,    1'b0};
    vecs[18] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, W3,    1'b0};
    vecs[19] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, W3,    1'b0};

    rst_n = 1'b0;
    repeat (2) @(posedge wclk);
    #1;
    rst_n = 1'b1;

    // Cycle-exact table: full pack, short packet, flush, idle flush.
    for (int i = 0; i < 20; i++) begin
      in_valid_i = vecs[i].vld;
      in_data_i  = vecs[i].dat;
      in_last_i  = vecs[i].lst;
      flush_i    = vecs[i].fl;
      @(negedge wclk);
      chk($sformatf("vec%0d_ready", i), 64'(in_ready_o), 64'(vecs[i].ready));
      chk($sformatf("vec%0d_push", i), 64'(push_o), 64'(vecs[i].push));
      chk($sformatf("vec%0d_data", i), data_in_o, vecs[i].data);
      chk($sformatf("vec%0d_busy", i), 64'(busy_o), 64'(vecs[i].busy));
      @(posedge wclk);
      #1;
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    flush_i    = 1'b0;

    // alFull throttling with a held word.
    sb_on     = 1'b1;
    al_full_i = 1'b1;
    send_beat(16'h0101, 1'b0);
    send_beat(16'h0202, 1'b0);
    send_beat(16'h0303, 1'b0);
    send_beat(16'h0404, 1'b0);
    in_valid_i = 1'b1;
    in_data_i  = 16'h5555;
    repeat (3) begin
      @(negedge wclk);
      chk("alfull_ready_low", 64'(in_ready_o), 64'(0));
      chk("alfull_no_push", 64'(push_o), 64'(0));
      @(posedge wclk);
      #1;
    end
    al_full_i = 1'b0;
    @(negedge wclk);
    chk("release_ready", 64'(in_ready_o), 64'(1));
    @(posedge wclk);
    #1;
    in_valid_i = 1'b0;
    model_beat(16'h5555, 1'b0);
    @(negedge wclk);
    chk("release_push", 64'(push_o), 64'(1));
    @(posedge wclk);
    #1;
    send_beat(16'h6666, 1'b0);
    send_beat(16'h7777, 1'b0);
    send_beat(16'h8888, 1'b0);
    drain();

    // Random full, frequent short packets (back-to-back completions), flushes.
    stream_on = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send_beat(16'($urandom()), ($urandom_range(0, 3) == 0));
      if (i % 17 == 16) send_flush();
    end
    send_flush();
    stream_on = 1'b0;
    drain();

    // Reset with two lanes filled.
    send_beat(16'hDEAD, 1'b0);
    send_beat(16'hBEEF, 1'b0);
    do_reset();

    // Reset with a word held behind alFull.
    al_full_i = 1'b1;
    send_beat(16'hCAFE, 1'b1);
    @(negedge wclk);
    chk("held_busy", 64'(busy_o), 64'(1));
    @(posedge wclk);
    #1;
    rst_n     = 1'b0;
    al_full_i = 1'b0;
    @(posedge wclk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    m_acc = '0;
    m_cnt = 0;
    @(negedge wclk);
    chk("rst_held_push", 64'(push_o), 64'(0));
    chk("rst_held_busy", 64'(busy_o), 64'(0));
    @(posedge wclk);
    #1;
    send_beat(16'hC001, 1'b0);
    send_beat(16'hC002, 1'b0);
    send_beat(16'hC003, 1'b0);
    send_beat(16'hC004, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
